edge_generator: RTL and testbench



---
 rtl/edge_gen_pkg.sv | 17 +
 rtl/edge_hold_timer.sv | 41 ++++
 rtl/edge_generator.sv | 135 +++++++++++++
 tb/tb_edge_generator.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/edge_gen_pkg.sv
// Shared types and defaults for the edge generator (serial level transmitter).
package edge_gen_pkg;

  localparam int unsigned EDGE_GEN_MIN_WIDTH = 4;

  typedef enum logic [1:0] {
    LOW_STABLE,
    LOW_HOLD,
    HIGH_STABLE,
    HIGH_HOLD
  } edge_gen_state_t;

  function automatic logic is_stable(edge_gen_state_t s);
    return (s == LOW_STABLE) || (s == HIGH_STABLE);
  endfunction

endpackage

// File: rtl/edge_hold_timer.sv
// Hold counter for the edge generator: loads MIN_WIDTH-1 on an edge and counts down to 0.
// expire_o is high during the last hold cycle; the counter reaches 0 on the following edge.
module edge_hold_timer
  import edge_gen_pkg::*;
#(
  parameter int unsigned MIN_WIDTH = EDGE_GEN_MIN_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = $clog2(MIN_WIDTH) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire_q, expire_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(MIN_WIDTH - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    expire_d = (cnt_d == CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/edge_generator.sv
// Serial edge generator: turns rise/fall request pulses into a registered level with a
// minimum hold per level. Optional one-deep request buffering during hold: EDGE_GEN_PENDING_EN.
module edge_generator
  import edge_gen_pkg::*;
#(
  parameter int unsigned MIN_WIDTH = EDGE_GEN_MIN_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic rise_req_i,
  input  logic fall_req_i,
  output logic a_o,
  output logic rise_ack_o,
  output logic fall_ack_o,
  output logic ready_o,
  output logic drop_o
);

  localparam bit HOLD_EN = (MIN_WIDTH > 1);

  edge_gen_state_t state_q, state_d;
  logic a_q, a_d;
  logic rise_ack_q, rise_ack_d;
  logic fall_ack_q, fall_ack_d;
  logic drop_q, drop_d;
  logic ready_q, ready_d;
  logic pend_q, pend_d;
  logic hold_load, hold_expire;
  logic any_req, want_edge, fire;

  edge_hold_timer #(.MIN_WIDTH(MIN_WIDTH)) u_hold_timer (
    .clk      (clk),
    .reset    (reset),
    .load_i   (hold_load),
    .expire_o (hold_expire)
  );

  // A request is usable only when it alone asks for the level opposite to the current one.
  assign any_req   = rise_req_i | fall_req_i;
  assign want_edge = a_q ? (fall_req_i & ~rise_req_i) : (rise_req_i & ~fall_req_i);

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    rise_ack_d = 1'b0;
    fall_ack_d = 1'b0;
    drop_d     = 1'b0;
    pend_d     = pend_q;
    hold_load  = 1'b0;
    fire       = 1'b0;

    case (state_q)
      LOW_STABLE, HIGH_STABLE: begin
        if (pend_q) begin
          fire   = 1'b1;
          pend_d = 1'b0;
          drop_d = any_req;
        end else if (want_edge) begin
          fire = 1'b1;
        end else begin
          drop_d = any_req;
        end
      end
      LOW_HOLD, HIGH_HOLD: begin
        if (hold_expire) begin
          state_d = (state_q == LOW_HOLD) ? LOW_STABLE : HIGH_STABLE;
        end
`ifdef EDGE_GEN_PENDING_EN
        if (want_edge && !pend_q) begin
          pend_d = 1'b1;
        end else begin
          drop_d = any_req;
        end
`else
        drop_d = any_req;
`endif
      end
      default: begin
        state_d = LOW_STABLE;
      end
    endcase

    // Flip the level and start the hold (skipped entirely when MIN_WIDTH is 1).
    if (fire) begin
      a_d        = ~a_q;
      rise_ack_d = ~a_q;
      fall_ack_d = a_q;
      hold_load  = HOLD_EN;
      if (a_q) begin
        state_d = HOLD_EN ? LOW_HOLD : LOW_STABLE;
      end else begin
        state_d = HOLD_EN ? HIGH_HOLD : HIGH_STABLE;
      end
    end

    ready_d = is_stable(state_d) && !pend_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LOW_STABLE;
      a_q        <= 1'b0;
      rise_ack_q <= 1'b0;
      fall_ack_q <= 1'b0;
      drop_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      rise_ack_q <= rise_ack_d;
      fall_ack_q <= fall_ack_d;
      drop_q     <= drop_d;
      ready_q    <= ready_d;
    end
  end

`ifdef EDGE_GEN_PENDING_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end
`else
  assign pend_q = 1'b0;
`endif

  assign a_o        = a_q;
  assign rise_ack_o = rise_ack_q;
  assign fall_ack_o = fall_ack_q;
  assign drop_o     = drop_q;
  assign ready_o    = ready_q;

endmodule

// File: tb/tb_edge_generator.sv
// Scoreboard bench for edge_generator: MIN_WIDTH=4 and MIN_WIDTH=1 instances share one
// request stream; a timestamp-based model predicts every cycle's outputs.
module tb_edge_generator;

  typedef struct {
    int lvl;
    int edge_cyc;  // first cycle the current level was visible
    bit pend;
  } model_t;

  typedef struct {
    int cyc;
    bit a;
    bit ra;
    bit fa;
    bit dr;
    bit rdy;
  } exp_t;

  logic clk = 1'b0;
  logic reset, rise, fall;
  logic a4, ra4, fa4, rdy4, dr4;
  logic a1, ra1, fa1, rdy1, dr1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t q4[$];
  exp_t q1[$];
  model_t m4, m1;

  logic det_prev;
  bit   count_en = 1'b0;
  int   det_r = 0, det_f = 0, ack_r = 0, ack_f = 0;

  edge_generator #(.MIN_WIDTH(4)) u4 (
    .clk(clk), .reset(reset), .rise_req_i(rise), .fall_req_i(fall),
    .a_o(a4), .rise_ack_o(ra4), .fall_ack_o(fa4), .ready_o(rdy4), .drop_o(dr4)
  );

  edge_generator #(.MIN_WIDTH(1)) u1 (
    .clk(clk), .reset(reset), .rise_req_i(rise), .fall_req_i(fall),
    .a_o(a1), .rise_ack_o(ra1), .fall_ack_o(fa1), .ready_o(rdy1), .drop_o(dr1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int c, input logic act, input bit expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0b expected=%0b", nm, c, act, expv);
    end
  endtask

  // Request at cycle n: edges allowed once the level has been visible for MIN_WIDTH cycles.
  task automatic model_step(input model_t mi, input int mw, input int n, input bit rst,
                            input bit r, input bit f, output model_t mo, output exp_t e);
    bit stable, any, want;
    mo = mi;
    e.cyc = n + 1; e.ra = 1'b0; e.fa = 1'b0; e.dr = 1'b0;
    if (rst) begin
      mo.lvl = 0; mo.edge_cyc = -1000; mo.pend = 1'b0;
    end else begin
      stable = (n >= mo.edge_cyc + mw - 1);
      any    = r | f;
      want   = (mo.lvl == 0) ? (r && !f) : (f && !r);
      if (stable && (mo.pend || want)) begin
        if (mo.pend && any) e.dr = 1'b1;
        mo.pend = 1'b0;
        mo.lvl = 1 - mo.lvl;
        mo.edge_cyc = n + 1;
        if (mo.lvl == 1) e.ra = 1'b1; else e.fa = 1'b1;
      end else if (stable) begin
        if (any) e.dr = 1'b1;
      end else begin
`ifdef EDGE_GEN_PENDING_EN
        if (want && !mo.pend) mo.pend = 1'b1;
        else if (any) e.dr = 1'b1;
`else
        if (any) e.dr = 1'b1;
`endif
      end
    end
    e.a   = (mo.lvl == 1);
    e.rdy = (n + 1 >= mo.edge_cyc + mw - 1) && !mo.pend;
  endtask

  task automatic drive(input bit rst, input bit r, input bit f);
    model_t m;
    exp_t e;
    reset = rst; rise = r; fall = f;
    model_step(m4, 4, cyc, rst, r, f, m, e); m4 = m; q4.push_back(e);
    model_step(m1, 1, cyc, rst, r, f, m, e); m1 = m; q1.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rand_cycle(input bit allow_rst);
    int r;
    bit rst;
    r   = int'($urandom_range(0, 99));
    rst = allow_rst && ($urandom_range(0, 199) == 0);
    if (r < 30)      drive(rst, 1'b1, 1'b0);
    else if (r < 60) drive(rst, 1'b0, 1'b1);
    else if (r < 65) drive(rst, 1'b1, 1'b1);
    else             drive(rst, 1'b0, 1'b0);
  endtask

  task automatic mon_inst(input string nm, input exp_t e, input logic a, input logic ra,
                          input logic fa, input logic dr, input logic rdy);
    chk({nm, "_a_o"},        e.cyc, a,   e.a);
    chk({nm, "_rise_ack_o"}, e.cyc, ra,  e.ra);
    chk({nm, "_fall_ack_o"}, e.cyc, fa,  e.fa);
    chk({nm, "_drop_o"},     e.cyc, dr,  e.dr);
    chk({nm, "_ready_o"},    e.cyc, rdy, e.rdy);
  endtask

  always @(posedge clk) det_prev <= a4;

  // Monitor: pops the expectation for the current cycle and compares mid-cycle.
  always @(negedge clk) begin
    while (q4.size() > 0 && q4[0].cyc <= cyc) begin
      mon_inst("u4", q4[0], a4, ra4, fa4, dr4, rdy4);
      void'(q4.pop_front());
    end
    while (q1.size() > 0 && q1[0].cyc <= cyc) begin
      mon_inst("u1", q1[0], a1, ra1, fa1, dr1, rdy1);
      void'(q1.pop_front());
    end
    if (count_en) begin
      if (a4 === 1'b1 && det_prev === 1'b0) det_r++;
      if (a4 === 1'b0 && det_prev === 1'b1) det_f++;
      if (ra4 === 1'b1) ack_r++;
      if (fa4 === 1'b1) ack_f++;
    end
  end

  initial begin
    reset = 1'b1; rise = 1'b0; fall = 1'b0;
    m4 = '{0, -1000, 1'b0};
    m1 = '{0, -1000, 1'b0};

    repeat (3) drive(1'b1, 1'b0, 1'b0);
    while (cyc < 10) drive(1'b0, 1'b0, 1'b0);
    // Rise at 10, fall at 14.
    drive(1'b0, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    repeat (6) drive(1'b0, 1'b0, 1'b0);
    // Fall two cycles after a rise: lands inside the hold.
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    repeat (6) drive(1'b0, 1'b0, 1'b0);
    // Same-polarity and simultaneous requests.
    drive(1'b0, 1'b1, 1'b0);
    repeat (5) drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    repeat (5) drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    // Requests piling up inside one hold.
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    repeat (6) drive(1'b0, 1'b0, 1'b0);
    // Back-to-back alternation from a clean low level.
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b0, (i % 2) == 0, (i % 2) == 1);
    repeat (5) drive(1'b0, 1'b0, 1'b0);
    // Reset while high.
    drive(1'b0, 1'b1, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 1'b0);

    repeat (2000) rand_cycle(1'b1);

    // Loopback phase: no resets, detector pulse counts must match the acks.
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    count_en = 1'b1;
    repeat (2000) rand_cycle(1'b0);
    repeat (8) drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    count_en = 1'b0;

    checks++;
    if (det_r != ack_r) begin
      failures++;
      $display("FAIL loopback_rise detector=%0d acks=%0d", det_r, ack_r);
    end
    checks++;
    if (det_f != ack_f) begin
      failures++;
      $display("FAIL loopback_fall detector=%0d acks=%0d", det_f, ack_f);
    end
    checks++;
    if (ack_r == 0) begin
      failures++;
      $display("FAIL loopback_activity rise_acks=%0d required=nonzero", ack_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
